// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall signal bundle between the pipeline datapath (master) and the stall controller (slave).
// STALL_PERF_CNT_EN adds the stall_cycles performance counter output.
interface pipeline_stall_controller_if #(
  parameter int RegAddrWidth = 5
);
  logic [RegAddrWidth-1:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used;
  logic ex_reg_wr_en, ex_mem_rd_en, ex_muldiv_start;
  logic muldiv_done, flush;
  logic stall_if, stall_id, stall_ex, bubble_ex;
  logic muldiv_busy, muldiv_timeout_err;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
    output ex_reg_wr_en, ex_mem_rd_en, ex_muldiv_start, muldiv_done, flush,
`ifdef STALL_PERF_CNT_EN
    input  stall_cycles,
`endif
    input  stall_if, stall_id, stall_ex, bubble_ex, muldiv_busy, muldiv_timeout_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
    input  ex_reg_wr_en, ex_mem_rd_en, ex_muldiv_start, muldiv_done, flush,
`ifdef STALL_PERF_CNT_EN
    output stall_cycles,
`endif
    output stall_if, stall_id, stall_ex, bubble_ex, muldiv_busy, muldiv_timeout_err
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Load-use bubble and multi-cycle MUL/DIV stall FSM with timeout abort.
// STALL_PERF_CNT_EN: adds a saturating 32-bit count of stall_if cycles.
module pipeline_stall_controller #(
  parameter int RegAddrWidth   = 5,
  parameter int MULDIV_TIMEOUT = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipeline_stall_controller_if.slave psc
);
  localparam int                     CntW        = 8;
  localparam logic [CntW-1:0]        TimeoutLast = CntW'(MULDIV_TIMEOUT - 1);
  localparam logic [RegAddrWidth-1:0] RegZero    = '0;

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MULDIV_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_set;
  logic            load_hazard;
  logic            stall_fe, stall_ex_c, bubble_c, busy_c;

  assign load_hazard = psc.ex_mem_rd_en & psc.ex_reg_wr_en & (psc.ex_rd != RegZero) &
                       ((psc.id_rs1_used & (psc.id_rs1 == psc.ex_rd)) |
                        (psc.id_rs2_used & (psc.id_rs2 == psc.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_set;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_set    = 1'b0;
    stall_fe   = 1'b0;
    stall_ex_c = 1'b0;
    bubble_c   = 1'b0;
    busy_c     = 1'b0;
    case (state_q)
      IDLE: begin
        // A MUL/DIV that finishes in its own start cycle needs no stall at all.
        if (psc.ex_muldiv_start) begin
          if (!psc.muldiv_done) begin
            stall_fe   = 1'b1;
            stall_ex_c = 1'b1;
            cnt_d      = '0;
            state_d    = MULDIV_WAIT;
          end
        end else if (load_hazard && !psc.flush) begin
          stall_fe = 1'b1;
          bubble_c = 1'b1;
          state_d  = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = IDLE;
      MULDIV_WAIT: begin
        if (psc.muldiv_done) begin
          state_d = IDLE;
        end else if (cnt_q == TimeoutLast) begin
          busy_c  = 1'b1;
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          busy_c     = 1'b1;
          stall_fe   = 1'b1;
          stall_ex_c = 1'b1;
          cnt_d      = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mealy outputs are gated so reset silences them without waiting for a clock.
  assign psc.stall_if           = stall_fe & rst_n;
  assign psc.stall_id           = stall_fe & rst_n;
  assign psc.stall_ex           = stall_ex_c & rst_n;
  assign psc.bubble_ex          = bubble_c & rst_n;
  assign psc.muldiv_busy        = busy_c & rst_n;
  assign psc.muldiv_timeout_err = err_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall_fe && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign psc.stall_cycles = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: table of single-hazard vectors plus multi-cycle MUL/DIV, timeout and reset sequences.
module tb_pipeline_stall_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.RegAddrWidth(5)) a ();
  pipeline_stall_controller_if #(.RegAddrWidth(5)) b ();

  // Second DUT with a short timeout shares the stimulus of the first.
  assign b.id_rs1          = a.id_rs1;
  assign b.id_rs2          = a.id_rs2;
  assign b.id_rs1_used     = a.id_rs1_used;
  assign b.id_rs2_used     = a.id_rs2_used;
  assign b.ex_rd           = a.ex_rd;
  assign b.ex_reg_wr_en    = a.ex_reg_wr_en;
  assign b.ex_mem_rd_en    = a.ex_mem_rd_en;
  assign b.ex_muldiv_start = a.ex_muldiv_start;
  assign b.muldiv_done     = a.muldiv_done;
  assign b.flush           = a.flush;

  pipeline_stall_controller #(.RegAddrWidth(5), .MULDIV_TIMEOUT(40)) dut (
    .clk(clk), .rst_n(rst_n), .psc(a)
  );
  pipeline_stall_controller #(.RegAddrWidth(5), .MULDIV_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .psc(b)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, st, dn, fl;
    logic [4:0] exp1, exp2;  // {stall_if, stall_id, stall_ex, bubble_ex, muldiv_busy}
  } vec_t;

  function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic ld, input logic st, input logic dn,
                              input logic fl, input logic [4:0] e1, input logic [4:0] e2);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.wr = wr; v.ld = ld; v.st = st; v.dn = dn; v.fl = fl; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  function automatic logic [4:0] outs_a();
    return {a.stall_if, a.stall_id, a.stall_ex, a.bubble_ex, a.muldiv_busy};
  endfunction

  function automatic logic [4:0] outs_b();
    return {b.stall_if, b.stall_id, b.stall_ex, b.bubble_ex, b.muldiv_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    a.id_rs1 = '0; a.id_rs2 = '0; a.id_rs1_used = 1'b0; a.id_rs2_used = 1'b0;
    a.ex_rd = '0; a.ex_reg_wr_en = 1'b0; a.ex_mem_rd_en = 1'b0;
    a.ex_muldiv_start = 1'b0; a.muldiv_done = 1'b0; a.flush = 1'b0;
  endtask

  task automatic hazard();
    a.id_rs1 = 5'd1; a.id_rs2 = 5'd5; a.id_rs1_used = 1'b1; a.id_rs2_used = 1'b1;
    a.ex_rd = 5'd5; a.ex_reg_wr_en = 1'b1; a.ex_mem_rd_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  vec_t       tbl[11];
  logic [4:0] o;

  initial begin
    tbl[0]  = mk("lu_rs2",       5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0, 5'b11010, 5'b00000);
    tbl[1]  = mk("rd_zero",      5'd1, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[2]  = mk("flush",        5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 1, 5'b00000, 5'b00000);
    tbl[3]  = mk("rs2_unused",   5'd1, 5'd5, 1, 0, 5'd5, 1, 1, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[4]  = mk("lu_rs1",       5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 0, 0, 0, 5'b11010, 5'b00000);
    tbl[5]  = mk("rs1_unused",   5'd5, 5'd2, 0, 1, 5'd5, 1, 1, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[6]  = mk("not_load",     5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[7]  = mk("no_wr",        5'd1, 5'd5, 1, 1, 5'd5, 0, 1, 0, 0, 0, 5'b00000, 5'b00000);
    tbl[8]  = mk("md_done_same", 5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0, 5'b00000, 5'b00000);
    tbl[9]  = mk("done_in_idle", 5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 1, 0, 5'b11010, 5'b00000);
    tbl[10] = mk("no_match",     5'd3, 5'd4, 1, 1, 5'd5, 1, 1, 0, 0, 0, 5'b00000, 5'b00000);

    // Reset: outputs stay low even while a hazard and a MUL/DIV start are presented.
    rst_n = 1'b0;
    quiet();
    #12;
    hazard(); a.ex_muldiv_start = 1'b1;
    #1;
    check("reset_outs", 32'(outs_a()), 32'h0);
    check("reset_outs_to", 32'(outs_b()), 32'h0);
    check("reset_err", 32'(a.muldiv_timeout_err), 32'h0);
    quiet();
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      a.id_rs1 = tbl[i].rs1; a.id_rs2 = tbl[i].rs2;
      a.id_rs1_used = tbl[i].u1; a.id_rs2_used = tbl[i].u2; a.ex_rd = tbl[i].rd;
      a.ex_reg_wr_en = tbl[i].wr; a.ex_mem_rd_en = tbl[i].ld;
      a.ex_muldiv_start = tbl[i].st; a.muldiv_done = tbl[i].dn; a.flush = tbl[i].fl;
      #1 check({tbl[i].name, "_c0"}, 32'(outs_a()), 32'(tbl[i].exp1));
      @(negedge clk);
      #1 check({tbl[i].name, "_c1"}, 32'(outs_a()), 32'(tbl[i].exp2));
      quiet();
    end

    // MUL/DIV start (with a simultaneous load hazard) and done five cycles later.
    @(negedge clk); hazard(); a.ex_muldiv_start = 1'b1;
    #1 check("md_start", 32'(outs_a()), 32'b11100);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); quiet();
      if (i == 2) a.flush = 1'b1;
      if (i == 5) a.muldiv_done = 1'b1;
      #1 check($sformatf("md_cycle%0d", i), 32'(outs_a()), (i < 5) ? 32'b11101 : 32'b00000);
    end
    @(negedge clk); quiet();
    #1 check("md_after", 32'(outs_a()), 32'h0);

    // Timeout on the short-timeout instance.
    do_reset();
    #1 check("to_err_clear", 32'(b.muldiv_timeout_err), 32'h0);
    @(negedge clk); a.ex_muldiv_start = 1'b1;
    #1 check("to_start", 32'(outs_b()), 32'b11100);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); quiet();
      #1;
      o = outs_b();
      if (i < 4) check($sformatf("to_wait%0d", i), 32'(o), 32'b11101);
      else       check("to_release", 32'(o[4:1]), 32'h0);
      check($sformatf("to_err_pre%0d", i), 32'(b.muldiv_timeout_err), 32'h0);
    end
    @(negedge clk);
    #1 check("to_idle", 32'(outs_b()), 32'h0);
    check("to_err_set", 32'(b.muldiv_timeout_err), 32'h1);
    @(negedge clk); hazard();
    #1 check("to_lu_after", 32'(outs_b()), 32'b11010);
    @(negedge clk); quiet();
    repeat (3) @(negedge clk);
    #1 check("to_err_sticky", 32'(b.muldiv_timeout_err), 32'h1);
    rst_n = 1'b0;
    #1 check("to_err_reset", 32'(b.muldiv_timeout_err), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of MULDIV_WAIT, then a normal load-use stall.
    @(negedge clk); a.ex_muldiv_start = 1'b1;
    @(negedge clk); quiet();
    #1 check("rst_wait1", 32'(outs_a()), 32'b11101);
    @(negedge clk);
    #1 check("rst_wait2", 32'(outs_a()), 32'b11101);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(outs_a()), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); hazard();
    #1 check("rst_lu_c0", 32'(outs_a()), 32'b11010);
    @(negedge clk);
    #1 check("rst_lu_c1", 32'(outs_a()), 32'h0);
    quiet();

`ifdef STALL_PERF_CNT_EN
    do_reset();
    @(negedge clk); hazard();
    @(negedge clk); quiet();
    @(negedge clk); a.ex_muldiv_start = 1'b1;
    @(negedge clk); quiet();
    @(negedge clk);
    @(negedge clk); a.muldiv_done = 1'b1;
    @(negedge clk); quiet();
    #1 check("perf_count", a.stall_cycles, 32'd4);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    @(negedge clk); hazard();
    @(negedge clk); quiet();
    #1 check("perf_near_sat", a.stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk); hazard();
    @(negedge clk); quiet();
    #1 check("perf_sat", a.stall_cycles, 32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
